// File: rtl/sega_sprite_line_engine.sv
// Sprite line comparator: scans NCH channels per line start, tests each channel's vertical window,
// steps per-line row pointers and drives up/down fetch counters onto the sprite ROM address bus.
module sega_sprite_line_engine #(
  parameter int unsigned CW  = 16,
  parameter int unsigned VW  = 8,
  parameter int unsigned NCH = 4,
  localparam int unsigned CHW = $clog2(NCH)
) (
  input  logic           i_MCLK,
  input  logic           i_RST,
  input  logic           i_CLK5MNCEN,
  input  logic [VW-1:0]  i_V,
  input  logic           i_LINE_START,
  input  logic           i_WR_EN,
  input  logic [CHW-1:0] i_WR_CH,
  input  logic [1:0]     i_WR_SEL,
  input  logic [CW-1:0]  i_WR_DATA,
  input  logic [CHW-1:0] i_FETCH_CH,
  input  logic           i_CWEN,
  input  logic           i_ONTRF,
  output logic [CW-1:0]  o_ADDR,
  output logic           o_ADDR_OE,
  output logic [NCH-1:0] o_HIT,
  output logic           o_VEN_n,
  output logic           o_SWAP,
  output logic           o_BUSY,
  output logic           o_SCAN_DONE
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [CHW-1:0] IdxLast = CHW'(NCH - 1);

  logic [VW-1:0]  top_q    [NCH];
  logic [VW-1:0]  top_d    [NCH];
  logic [VW-1:0]  height_q [NCH];
  logic [VW-1:0]  height_d [NCH];
  logic [CW-1:0]  base_q   [NCH];
  logic [CW-1:0]  base_d   [NCH];
  logic [CW-1:0]  stride_q [NCH];
  logic [CW-1:0]  stride_d [NCH];
  logic [CW-1:0]  ptr_q    [NCH];
  logic [CW-1:0]  ptr_d    [NCH];
  logic [CW-1:0]  fcnt_q   [NCH];
  logic [CW-1:0]  fcnt_d   [NCH];
  logic [VW-1:0]  vlat_q, vlat_d;
  logic [CHW-1:0] idx_q, idx_d;
  logic [NCH-1:0] hit_q, hit_d;
  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [VW-1:0]  scan_dist;
  logic           scan_hit;
  logic [CW-1:0]  scan_load;
  logic [CW-1:0]  fetch_cnt;

  // Scan always reads pre-write register values of the channel at idx_q.
  assign scan_dist = vlat_q - top_q[idx_q];
  assign scan_hit  = scan_dist < height_q[idx_q];
  assign scan_load = (scan_dist == '0) ? base_q[idx_q] : ptr_q[idx_q] + stride_q[idx_q];
  assign fetch_cnt = fcnt_q[i_FETCH_CH];

  always_comb begin
    top_d    = top_q;
    height_d = height_q;
    base_d   = base_q;
    stride_d = stride_q;
    ptr_d    = ptr_q;
    fcnt_d   = fcnt_q;
    vlat_d   = vlat_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    state_d  = state_q;
    if (i_CLK5MNCEN) begin
      if (i_CWEN) begin
        fcnt_d[i_FETCH_CH] = fetch_cnt[CW-1] ? fetch_cnt - 1'b1 : fetch_cnt + 1'b1;
      end
      if (i_LINE_START) begin
        vlat_d  = i_V;
        hit_d   = '0;
        idx_d   = '0;
        state_d = StScan;
      end else begin
        unique case (state_q)
          StScan: begin
            // Placed after the CWEN step so a scan load overrides it.
            if (scan_hit) begin
              ptr_d[idx_q]  = scan_load;
              fcnt_d[idx_q] = scan_load;
              hit_d[idx_q]  = 1'b1;
            end
            if (idx_q == IdxLast) state_d = StDone;
            else                  idx_d   = idx_q + 1'b1;
          end
          StDone:  state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
      if (i_WR_EN) begin
        unique case (i_WR_SEL)
          2'd0: top_d[i_WR_CH]    = i_WR_DATA[VW-1:0];
          2'd1: height_d[i_WR_CH] = i_WR_DATA[VW-1:0];
          2'd2: base_d[i_WR_CH]   = i_WR_DATA;
          2'd3: stride_d[i_WR_CH] = i_WR_DATA;
        endcase
      end
    end
    busy_d = (state_d == StScan);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      for (int i = 0; i < NCH; i++) begin
        top_q[i]    <= '0;
        height_q[i] <= '0;
        base_q[i]   <= '0;
        stride_q[i] <= '0;
        ptr_q[i]    <= '0;
        fcnt_q[i]   <= '0;
      end
      vlat_q  <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      top_q    <= top_d;
      height_q <= height_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      ptr_q    <= ptr_d;
      fcnt_q   <= fcnt_d;
      vlat_q   <= vlat_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_ADDR      = fetch_cnt;
  assign o_ADDR_OE   = i_ONTRF;
  assign o_HIT       = hit_q;
  assign o_VEN_n     = ~|hit_q;
  assign o_SWAP      = fetch_cnt[CW-1] ^ ~i_CWEN;
  assign o_BUSY      = busy_q;
  assign o_SCAN_DONE = done_q;

endmodule
